// File: rtl/switch_debounce_if.sv
// Switch conditioning bus: raw pins in, debounced levels and one-cycle edge pulses out.
// The stimulus/consumer side takes master, the debouncer takes slave.
interface switch_debounce_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] s_rise;
  logic [WIDTH-1:0] s_fall;
  logic             s_changed;

  modport master (
    output sw_raw,
    input  s,
    input  s_rise,
    input  s_fall,
    input  s_changed
  );

  modport slave (
    input  sw_raw,
    output s,
    output s_rise,
    output s_fall,
    output s_changed
  );
endinterface

// File: rtl/switch_debounce.sv
// Per-channel synchronizer plus STABLE/SETTLING debounce FSM for raw DIP-switch pins.
// A new level is accepted once DEBOUNCE_CYCLES consecutive synchronized samples disagree with s.
module switch_debounce #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic             int_osc,
  input  logic             reset,
  switch_debounce_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } state_t;

  logic [WIDTH-1:0] level_vec;
  logic [WIDTH-1:0] rise_vec;
  logic [WIDTH-1:0] fall_vec;
  logic [WIDTH-1:0] commit_vec;
  logic             changed_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   sw_sync;
      logic                   mismatch;
      state_t                 state_reg;
      logic [CNT_W-1:0]       count_reg;
      logic                   level_reg;
      logic                   rise_reg;
      logic                   fall_reg;

      always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.sw_raw[gi]};
        end
      end

      assign sw_sync  = sync_reg[SYNC_STAGES-1];
      assign mismatch = (sw_sync != level_reg);
      // count_reg holds the disagreeing samples already seen, so the current one is the last needed
      assign commit_vec[gi] = (state_reg == SETTLING) && mismatch && (count_reg >= CNT_LAST);

      always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
          state_reg <= STABLE;
          count_reg <= '0;
          level_reg <= 1'b0;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
        end else begin
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
          case (state_reg)
            STABLE: begin
              if (mismatch) begin
                state_reg <= SETTLING;
                count_reg <= CNT_ONE;
              end else begin
                count_reg <= '0;
              end
            end
            SETTLING: begin
              if (!mismatch) begin
                state_reg <= STABLE;
                count_reg <= '0;
              end else if (commit_vec[gi]) begin
                state_reg <= STABLE;
                count_reg <= '0;
                level_reg <= sw_sync;
                rise_reg  <= sw_sync;
                fall_reg  <= ~sw_sync;
              end else begin
                count_reg <= count_reg + CNT_ONE;
              end
            end
            default: begin
              state_reg <= STABLE;
              count_reg <= '0;
            end
          endcase
        end
      end

      assign level_vec[gi] = level_reg;
      assign rise_vec[gi]  = rise_reg;
      assign fall_vec[gi]  = fall_reg;
    end
  endgenerate

  // Registered from the same commit condition so it lines up with the per-bit pulses
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      changed_reg <= 1'b0;
    end else begin
      changed_reg <= |commit_vec;
    end
  end

  assign bus.s         = level_vec;
  assign bus.s_rise    = rise_vec;
  assign bus.s_fall    = fall_vec;
  assign bus.s_changed = changed_reg;

endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce: directed latency/reset cases plus random bounce bursts,
// compared every cycle against a sliding-window model of the synchronized samples.
module tb_switch_debounce;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int DC   = 4;
  localparam int H    = SYNC + DC;

  logic int_osc = 1'b0;
  logic reset   = 1'b0;

  switch_debounce_if #(.WIDTH(W)) bus ();

  switch_debounce #(
    .WIDTH(W),
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .int_osc(int_osc),
    .reset(reset),
    .bus(bus)
  );

  always #5 int_osc = ~int_osc;

  int n_cmp = 0;
  int n_bad = 0;
  int obs_pulses = 0;
  int exp_pulses = 0;

  // Model: hist[0] is the raw value sampled at the latest edge; the FSM acts on hist[SYNC..H-1]
  logic [W-1:0] hist [0:H-1];
  logic [W-1:0] m_s, m_rise, m_fall;
  logic         m_chg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < H; i++) hist[i] = '0;
    m_s    = '0;
    m_rise = '0;
    m_fall = '0;
    m_chg  = 1'b0;
  endtask

  task automatic model_step(input logic [W-1:0] raw);
    if (!reset) begin
      model_reset();
    end else begin
      for (int i = H - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = raw;
      m_rise = '0;
      m_fall = '0;
      for (int ch = 0; ch < W; ch++) begin
        logic v;
        logic same;
        v    = hist[SYNC][ch];
        same = 1'b1;
        for (int j = SYNC; j < H; j++) if (hist[j][ch] != v) same = 1'b0;
        if (same && (v != m_s[ch])) begin
          m_s[ch] = v;
          if (v) m_rise[ch] = 1'b1;
          else   m_fall[ch] = 1'b1;
        end
      end
      m_chg = |(m_rise | m_fall);
    end
  endtask

  task automatic check_all();
    check("s", bus.s, m_s);
    check("s_rise", bus.s_rise, m_rise);
    check("s_fall", bus.s_fall, m_fall);
    check("s_changed", bus.s_changed, m_chg);
  endtask

  // Called at a negedge: drive, let one rising edge sample it, check on the next negedge
  task automatic tick(input logic [W-1:0] raw);
    bus.sw_raw = raw;
    @(posedge int_osc);
    model_step(raw);
    @(negedge int_osc);
    check_all();
    obs_pulses += $countones(bus.s_rise | bus.s_fall);
    exp_pulses += $countones(m_rise | m_fall);
  endtask

  task automatic hold(input logic [W-1:0] raw, input int n);
    for (int i = 0; i < n; i++) tick(raw);
  endtask

  initial begin
    logic [W-1:0] lvl;
    int           blen;
    int           hlen;

    bus.sw_raw = '0;
    model_reset();
    #3;
    $display("reset: checking outputs held low");
    check_all();
    @(negedge int_osc);
    reset = 1'b1;

    $display("txn 0000->0001: expect s[0] on the 6th sampled edge");
    for (int i = 1; i <= 7; i++) begin
      tick(4'b0001);
      check("lat_s", bus.s, (i >= 6) ? 4'b0001 : 4'b0000);
      check("lat_rise", bus.s_rise, (i == 6) ? 4'b0001 : 4'b0000);
      check("lat_chg", bus.s_changed, (i == 6) ? 1'b1 : 1'b0);
    end

    $display("txn glitch on bit1 for 3 clocks: expect no change");
    for (int i = 1; i <= 10; i++) begin
      tick((i <= 3) ? 4'b0011 : 4'b0001);
      check("glitch_s", bus.s, 4'b0001);
      check("glitch_chg", bus.s_changed, 1'b0);
    end

    $display("txn 1111->0101: expect s_fall 1010 once");
    hold(4'b1111, 8);
    for (int i = 1; i <= 7; i++) begin
      tick(4'b0101);
      check("multi_s", bus.s, (i >= 6) ? 4'b0101 : 4'b1111);
      check("multi_fall", bus.s_fall, (i == 6) ? 4'b1010 : 4'b0000);
    end

    $display("txn async reset with s=1111, then release with raw=1111");
    hold(4'b1111, 8);
    check("pre_rst_s", bus.s, 4'b1111);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_s", bus.s, 4'b0000);
    check("async_rise", bus.s_rise, 4'b0000);
    check("async_fall", bus.s_fall, 4'b0000);
    check("async_chg", bus.s_changed, 1'b0);
    @(negedge int_osc);
    hold(4'b1111, 2);
    reset = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(4'b1111);
      check("post_rst_s", bus.s, (i >= 6) ? 4'b1111 : 4'b0000);
      check("post_rst_rise", bus.s_rise, (i == 6) ? 4'b1111 : 4'b0000);
    end

    $display("txn reset during settling on bit2");
    hold(4'b0000, 8);
    hold(4'b0100, 4);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("mid_rst_s", bus.s, 4'b0000);
    @(negedge int_osc);
    for (int i = 0; i < 3; i++) begin
      tick(4'b0100);
      check("in_rst_s", bus.s, 4'b0000);
      check("in_rst_chg", bus.s_changed, 1'b0);
    end
    reset = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(4'b0100);
      check("rel_s", bus.s, (i >= 6) ? 4'b0100 : 4'b0000);
      check("rel_rise", bus.s_rise, (i == 6) ? 4'b0100 : 4'b0000);
    end

    for (int b = 0; b < 40; b++) begin
      blen = $urandom_range(0, 3);
      lvl  = W'($urandom);
      hlen = $urandom_range(1, 9);
      $display("burst %0d: bounce=%0d level=%b hold=%0d", b, blen, lvl, hlen);
      for (int i = 0; i < blen; i++) tick(W'($urandom));
      hold(lvl, hlen);
    end
    hold(lvl, 8);
    check("final_s", bus.s, lvl);
    check("pulse_total", obs_pulses, exp_pulses);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Purpose: upstream conditioning stage that turns raw DIP-switch pins into clean, glitch-free switch levels and edge pulses for the LED/segment control logic.

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, meaning the number of independent switch channels.
REQ-002 The module SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer flop depth; legal values are 2 or greater.
REQ-003 The module SHALL have parameter DEBOUNCE_CYCLES, default 240000 (10 ms at 24 MHz), meaning the required stable period in clocks; legal values are 2 or greater.
REQ-004 The module SHALL have port int_osc, input, 1 bit: the sole clock, from the on-chip 24 MHz HSOSC; all flops use its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port sw_raw, input, WIDTH bits: raw, asynchronous switch pins.
REQ-007 The module SHALL have port s, output, WIDTH bits: the debounced switch levels.
REQ-008 The module SHALL have port s_rise, output, WIDTH bits: a one-cycle pulse per bit when s[i] goes 0->1.
REQ-009 The module SHALL have port s_fall, output, WIDTH bits: a one-cycle pulse per bit when s[i] goes 1->0.
REQ-010 The module SHALL have port s_changed, output, 1 bit: the OR-reduction of s_rise and s_fall.

Function
REQ-011 Each sw_raw[i] SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is sw_sync[i], and no logic other than that chain SHALL observe sw_raw.
REQ-012 Each channel SHALL run an independent 2-state FSM with states STABLE and SETTLING, plus a counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-013 The STABLE to SETTLING transition SHALL occur when sw_sync[i] != s[i]; the counter loads 1.
REQ-014 While in SETTLING with sw_sync[i] == s[i] (bounce back), the FSM SHALL return to STABLE, clear the counter to 0, and leave s[i] unchanged with no pulse.
REQ-015 While in SETTLING with sw_sync[i] != s[i] and counter < DEBOUNCE_CYCLES, the counter SHALL increment by 1 and never wrap.
REQ-016 While in SETTLING with sw_sync[i] != s[i] and counter == DEBOUNCE_CYCLES, on that edge the module SHALL set s[i] <= sw_sync[i], clear the counter, and return to STABLE.
REQ-017 Latency: a clean raw transition first sampled at edge k SHALL appear on s[i] at edge k + SYNC_STAGES + DEBOUNCE_CYCLES - 1, exactly.
REQ-018 s_rise[i] and s_fall[i] SHALL be registered and high during exactly the one cycle in which s[i] holds its new value, and low otherwise.
REQ-019 s_rise[i] and s_fall[i] SHALL never be high in the same cycle.
REQ-020 Channels SHALL be fully independent; simultaneous transitions on several bits SHALL each follow REQ-013 to REQ-018, and s_changed is high if any bit pulses.
REQ-021 Raw glitches shorter than DEBOUNCE_CYCLES consecutive synchronized cycles SHALL never change s or produce a pulse.
REQ-022 A channel in STABLE with sw_sync[i] == s[i] SHALL hold its counter at 0.

Reset
REQ-023 While reset is low, the synchronizer flops, s, s_rise, s_fall, s_changed and all counters SHALL be 0, and all FSMs SHALL be in STABLE, asynchronously and regardless of the clock.
REQ-024 A reset asserted mid-SETTLING SHALL discard the partial count, and no pulse SHALL be emitted.
REQ-025 After reset deasserts with sw_raw[i] = 1, s[i] SHALL rise after the full REQ-017 latency, with one s_rise[i] pulse.

Verification (bench parameters: DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2, WIDTH = 4)
REQ-026 Drive sw_raw 0000 to 0001, held, first sampled at edge k -> s = 0001 at edge k+5; s_rise = 0001 and s_changed = 1 for that one cycle only.
REQ-027 Toggle sw_raw[1] high for 3 clocks, then low -> s[1] stays 0; no s_rise, s_fall or s_changed pulse.
REQ-028 Drive sw_raw 1111 to 0101 simultaneously, held -> s = 0101 five edges later; s_fall = 1010 for one cycle.
REQ-029 Pulse reset low during SETTLING on bit 2, then release with sw_raw[2] = 1 -> s[2] = 0 throughout reset, no pulse, then rises 5 edges after the first post-reset sample with one s_rise[2] pulse.
REQ-030 Assert reset asynchronously between clock edges with s = 1111 -> s, the pulses and s_changed read 0 immediately, before the next clock edge.
REQ-031 Apply random bounce bursts under 4 cycles followed by a stable level -> a scoreboard confirms exactly one edge pulse per committed level change and s matches the reference latency.
